// File: rtl/jacobi_pkg.sv
// Shared types and default sizing for the Jacobi rotation datapath.
// No logic; constants and types only.
// Imported by the output FIFO, its interface and the controller side.
package jacobi_pkg;

  localparam int WORD_WIDTH_DEF = 20;
  localparam int DEPTH_DEF      = 16;
  localparam int AF_THRESH_DEF  = 12;

  typedef struct packed {
    logic [WORD_WIDTH_DEF-1:0] x;
    logic [WORD_WIDTH_DEF-1:0] y;
    logic [WORD_WIDTH_DEF-1:0] z;
  } rot_triple_t;

endpackage

// File: rtl/jacobi_rotation_out_fifo_if.sv
// Push (CORDIC side, valid only) and pop (controller side, valid/ready) channels.
// No logic; wires only.
// The push side carries no ready; the pop side uses out_rdy_i.
interface jacobi_rotation_out_fifo_if
  import jacobi_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF
);
  logic [WORD_WIDTH-1:0] in_dat_x_i;
  logic [WORD_WIDTH-1:0] in_dat_y_i;
  logic [WORD_WIDTH-1:0] in_dat_z_i;
  logic                  in_vld_i;
  logic [WORD_WIDTH-1:0] out_dat_x_o;
  logic [WORD_WIDTH-1:0] out_dat_y_o;
  logic [WORD_WIDTH-1:0] out_dat_z_o;
  logic                  out_vld_o;
  logic                  out_rdy_i;

  // FIFO side
  modport slave (
    input  in_dat_x_i, in_dat_y_i, in_dat_z_i, in_vld_i, out_rdy_i,
    output out_dat_x_o, out_dat_y_o, out_dat_z_o, out_vld_o
  );

  // CORDIC / controller side
  modport master (
    output in_dat_x_i, in_dat_y_i, in_dat_z_i, in_vld_i, out_rdy_i,
    input  out_dat_x_o, out_dat_y_o, out_dat_z_o, out_vld_o
  );
endinterface

// File: rtl/jacobi_fifo_mem.sv
// Simple dual-port triple storage: synchronous write, asynchronous read.
// Write lands on the clock edge; read data follows raddr_i combinationally.
// No flow control; the caller guards we_i.
module jacobi_fifo_mem #(
  parameter  int DATA_WIDTH = 60,
  parameter  int DEPTH      = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write port; contents are intentionally not reset so this maps to distributed RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/jacobi_rotation_out_fifo.sv
// First-word-fall-through buffer for rotation CORDIC (x,y,z) results.
// Latency: push in cycle N is visible at the output in cycle N+1; no pass-through.
// Push side has no ready: pushes into a full FIFO without a pop are dropped and flagged sticky.
module jacobi_rotation_out_fifo
  import jacobi_pkg::*;
#(
  parameter  int WORD_WIDTH         = WORD_WIDTH_DEF,
  parameter  int DEPTH              = DEPTH_DEF,
  parameter  int ALMOST_FULL_THRESH = AF_THRESH_DEF,
  localparam int ADDR_WIDTH         = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_i,
  jacobi_rotation_out_fifo_if.slave fifo_if,
  output logic [ADDR_WIDTH:0]     level_o,
  output logic                    empty_o,
  output logic                    full_o,
  output logic                    almost_full_o,
  output logic                    overflow_o
);

  localparam int                DW       = 3 * WORD_WIDTH;
  localparam logic [ADDR_WIDTH:0] LVL_FULL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LVL_AF   = (ADDR_WIDTH + 1)'(ALMOST_FULL_THRESH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic                  out_vld;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  mem_we;
  logic [DW-1:0]         wr_dat;
  logic [DW-1:0]         rd_dat;

  // Status comes from registered state only, so no input reaches these outputs combinationally.
  assign out_vld       = (level_q != '0);
  assign full          = (level_q == LVL_FULL);
  assign level_o       = level_q;
  assign empty_o       = !out_vld;
  assign full_o        = full;
  assign almost_full_o = (level_q >= LVL_AF);
  assign overflow_o    = overflow_q;

  assign fifo_if.out_vld_o = out_vld;
  assign wr_dat            = {fifo_if.in_dat_x_i, fifo_if.in_dat_y_i, fifo_if.in_dat_z_i};
  assign {fifo_if.out_dat_x_o, fifo_if.out_dat_y_o, fifo_if.out_dat_z_o} = rd_dat;

  // A pop frees the slot in the same cycle, so a full FIFO can still accept a push alongside it.
  assign pop    = out_vld & fifo_if.out_rdy_i;
  assign push   = fifo_if.in_vld_i & (!full | pop);
  assign mem_we = push & !clear_i & !rst;

  // Next-state for pointers, level and overflow; clear wins over push/pop.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (clear_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      end
      if (push && !pop) begin
        level_d = level_q + (ADDR_WIDTH + 1)'(1);
      end else if (pop && !push) begin
        level_d = level_q - (ADDR_WIDTH + 1)'(1);
      end
      if (fifo_if.in_vld_i && !push) begin
        overflow_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  jacobi_fifo_mem #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_dat),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_dat)
  );

endmodule

// File: tb/tb_jacobi_rotation_out_fifo.sv
// Bench for the rotation output FIFO: directed push/pop sequences with a scoreboard monitor.
// Stimulus changes 1 time unit after the rising edge; the monitor samples on the falling edge.
// Expected contents are queued by the stimulus; level/flags come from an independent cycle model.
module tb_jacobi_rotation_out_fifo;
  import jacobi_pkg::*;

  localparam int W     = 20;
  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic       clk;
  logic       rst;
  logic       clear_i;
  logic [4:0] level_o;
  logic       empty_o;
  logic       full_o;
  logic       almost_full_o;
  logic       overflow_o;

  jacobi_rotation_out_fifo_if #(.WORD_WIDTH(W)) bus ();

  jacobi_rotation_out_fifo #(
    .WORD_WIDTH         (W),
    .DEPTH              (DEPTH),
    .ALMOST_FULL_THRESH (AF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (clear_i),
    .fifo_if       (bus),
    .level_o       (level_o),
    .empty_o       (empty_o),
    .full_o        (full_o),
    .almost_full_o (almost_full_o),
    .overflow_o    (overflow_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        mon_en   = 1'b0;
  rot_triple_t exp_q[$];
  int          exp_level = 0;
  logic        exp_ovf   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: cycle model for level/flags plus head-of-queue data check.
  initial begin
    logic pop_m;
    logic push_m;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("level", 64'(level_o), 64'(exp_level));
        check("out_vld", 64'(bus.out_vld_o), 64'(exp_level != 0));
        check("empty", 64'(empty_o), 64'(exp_level == 0));
        check("full", 64'(full_o), 64'(exp_level == DEPTH));
        check("almost_full", 64'(almost_full_o), 64'(exp_level >= AF));
        check("overflow", 64'(overflow_o), 64'(exp_ovf));
        if (bus.out_vld_o === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("head_unexpected", 64'(1), 64'(0));
          end else begin
            check("head_data", 64'({bus.out_dat_x_o, bus.out_dat_y_o, bus.out_dat_z_o}),
                  64'(exp_q[0]));
          end
        end
        pop_m = (exp_level != 0) && (bus.out_rdy_i === 1'b1);
        if (rst || clear_i) begin
          exp_level = 0;
          exp_ovf   = 1'b0;
          exp_q.delete();
        end else begin
          push_m = bus.in_vld_i && ((exp_level < DEPTH) || pop_m);
          if (bus.in_vld_i && !push_m) exp_ovf = 1'b1;
          if (pop_m && exp_q.size() > 0) void'(exp_q.pop_front());
          exp_level = exp_level + int'(push_m) - int'(pop_m);
        end
      end
    end
  end

  // One cycle of stimulus; queues the triple if the bench expects the FIFO to accept it.
  task automatic step(input logic vld, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [W-1:0] z, input logic rdy, input logic exp_acc);
    rot_triple_t t;
    bus.in_vld_i   = vld;
    bus.in_dat_x_i = x;
    bus.in_dat_y_i = y;
    bus.in_dat_z_i = z;
    bus.out_rdy_i  = rdy;
    if (exp_acc) begin
      t.x = x;
      t.y = y;
      t.z = z;
      exp_q.push_back(t);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, '0, '0, '0, rdy, 1'b0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 64) begin
      idle(1'b1);
      guard++;
    end
    idle(1'b0);
    check("drain_complete", 64'(exp_q.size()), 64'(0));
  endtask

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r;
    logic v;
    rst            = 1'b1;
    clear_i        = 1'b0;
    bus.in_vld_i   = 1'b0;
    bus.in_dat_x_i = '0;
    bus.in_dat_y_i = '0;
    bus.in_dat_z_i = '0;
    bus.out_rdy_i  = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    repeat (2) idle(1'b0);
    rst = 1'b0;
    idle(1'b0);

    // Single triple: visible next cycle, then popped.
    step(1'b1, 20'h00011, 20'h00022, 20'h00033, 1'b0, 1'b1);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // Fill to full with no pops.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, W'(32'h10000 + i), W'(32'h20000 + i), W'(32'h30000 + i), 1'b0, 1'b1);
    end
    idle(1'b0);
    // Push into full with no pop: dropped, overflow next cycle.
    step(1'b1, 20'hAAAAA, 20'hBBBBB, 20'hCCCCC, 1'b0, 1'b0);
    idle(1'b0);
    // Push and pop together while full: level stays at DEPTH, new triple at the tail.
    step(1'b1, 20'h10010, 20'h20010, 20'h30010, 1'b1, 1'b1);
    idle(1'b0);
    drain();

    // Flush with a few entries stored and overflow still set; simultaneous push ignored.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, W'(32'h40000 + i), W'(32'h50000 + i), W'(32'h60000 + i), 1'b0, 1'b1);
    end
    clear_i = 1'b1;
    step(1'b1, 20'hDEAD0, 20'hDEAD1, 20'hDEAD2, 1'b1, 1'b0);
    clear_i = 1'b0;
    idle(1'b0);
    idle(1'b1);

    // Streaming: push whenever not almost full, random ready.
    for (int i = 0; i < 100; i++) begin
      v = !almost_full_o;
      r = 1'($urandom_range(1, 0));
      step(v, W'($urandom), W'($urandom), W'($urandom), r, v);
    end
    drain();

    // Reset with 5 entries stored and a push in the reset cycle.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, W'(32'h70000 + i), W'(32'h80000 + i), W'(32'h90000 + i), 1'b0, 1'b1);
    end
    rst = 1'b1;
    step(1'b1, 20'hBAD00, 20'hBAD01, 20'hBAD02, 1'b0, 1'b0);
    rst = 1'b0;
    idle(1'b0);
    step(1'b1, 20'h12345, 20'h23456, 20'h34567, 1'b0, 1'b1);
    idle(1'b0);
    drain();

    repeat (2) idle(1'b0);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jacobi_rotation_out_fifo.md
Name: jacobi_rotation_out_fifo

Overview:
Buffers (x, y, z) result triples from the pipelined rotation CORDIC and presents them to the Jacobi main controller for write-back to matrix RAM. The rotation CORDIC has no backpressure: valid only, one triple per cycle. This block absorbs bursts while the controller is busy with RAM port A/B.
- Provides a ready/valid pop interface.
- Provides level, full and empty status.
- Provides an almost-full flag, so the controller stops issuing rotations before results can be lost.

Parameters:
WORD_WIDTH, 20, width of each of x, y, z; equals the controller OUT_WORD_WIDTH.
DEPTH, 16, number of triple entries; must be a power of two, at least 4.
ADDR_WIDTH, $clog2(DEPTH), pointer width; derived, not overridden.
ALMOST_FULL_THRESH, 12, level at or above which almost_full_o asserts; must satisfy 1 <= value <= DEPTH.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  synchronous reset, active high.
clear_i  in  1  synchronous flush; empties the FIFO and clears overflow.
in_dat_x_i  in  WORD_WIDTH  rotation CORDIC x result.
in_dat_y_i  in  WORD_WIDTH  rotation CORDIC y result.
in_dat_z_i  in  WORD_WIDTH  rotation CORDIC residual angle z.
in_vld_i  in  1  push strobe; there is no ready back to the CORDIC.
out_dat_x_o  out  WORD_WIDTH  head entry x.
out_dat_y_o  out  WORD_WIDTH  head entry y.
out_dat_z_o  out  WORD_WIDTH  head entry z.
out_vld_o  out  1  head entry is valid (equals !empty).
out_rdy_i  in  1  controller accepts the head entry.
level_o  out  ADDR_WIDTH+1  number of stored entries.
empty_o  out  1  level_o == 0.
full_o  out  1  level_o == DEPTH.
almost_full_o  out  1  level_o >= ALMOST_FULL_THRESH.
overflow_o  out  1  sticky; a push was dropped.

Behaviour:
Storage and pointers:
- Storage is DEPTH x (3*WORD_WIDTH), with write pointer wr_ptr_r and read pointer rd_ptr_r, each ADDR_WIDTH bits.
- Both pointers wrap modulo DEPTH naturally.
- The level counter is level_r, ADDR_WIDTH+1 bits wide.

Reset:
- rst=1 sets wr_ptr_r=0, rd_ptr_r=0, level_r=0 and overflow_r=0.
- Resulting outputs: out_vld_o=0, empty_o=1, full_o=0, almost_full_o=0, overflow_o=0, level_o=0.
- Storage contents are not reset.
- out_dat_*_o are don't-care while out_vld_o=0.
- Reset mid-burst discards every entry, and pushes in the reset cycle are ignored.

Priority: rst > clear_i > push/pop.
- clear_i has the same effect as reset on pointers, level and overflow, and ignores a simultaneous push or pop.

Read side:
- The read side is first-word-fall-through: out_dat_*_o is driven combinationally from storage[rd_ptr_r].
- pop = out_vld_o & out_rdy_i.
- On pop, rd_ptr_r advances by 1.

Write side:
- push = in_vld_i & (!full_o | pop).
- A push writes storage[wr_ptr_r] and advances wr_ptr_r by 1.

Latency and throughput:
- A push in cycle N is visible at out_vld_o/out_dat in cycle N+1.
- There is no same-cycle pass-through.
- Sustained throughput is one push and one pop per cycle.

Level update:
- push only: +1.
- pop only: -1.
- push and pop together: unchanged.

Boundary conditions:
- Full with in_vld_i=1 and pop=1: the push is accepted, so level stays at DEPTH.
- Full with in_vld_i=1 and no pop: the data is dropped, overflow_r is set in the next cycle, and pointers and level are unchanged.
- Empty with out_rdy_i=1: no pop happens and the pointers are unchanged.
- Empty with in_vld_i=1 and out_rdy_i=1: only the push happens; the entry appears the next cycle.
- overflow_o stays high until rst or clear_i.
- The status outputs are registered or derived from level_r only, with no combinational path from the inputs.
- The out_rdy_i to out_vld_o path is also registered, because out_vld_o = level_r != 0.

Controller contract:
- The controller must stop issuing rotation inputs while almost_full_o=1.
- ALMOST_FULL_THRESH must be at most DEPTH minus (CORDIC latency + 1), so in-flight results still fit.

Decomposition:
Shared package jacobi_pkg:
- WORD_WIDTH default constant.
- typedef rot_triple_t, a packed struct {x, y, z} used for storage and for controller-side ports.
- DEPTH and ALMOST_FULL_THRESH defaults.

Sub-module:
- One natural sub-module: jacobi_fifo_mem, a DEPTH x 3*WORD_WIDTH simple-dual-port array with a synchronous write port and an asynchronous read port, so it can map to distributed RAM.
- Pointer, level and flag logic stay in the top level.

Test Plan:
- Reset, then push 1 triple (x=0x00011, y=0x00022, z=0x00033): the triple appears with out_vld_o=1 one cycle after the push, level_o=1; pop it, then empty_o=1.
- Push 16 distinct triples with out_rdy_i=0: full_o=1, level_o=16; almost_full_o rises the cycle after the 12th push; draining gives the triples in order 0..15.
- While full, push 1 extra triple with out_rdy_i=0: it is dropped, overflow_o=1 the next cycle, level_o stays 16; then clear_i for one cycle gives level_o=0 and overflow_o=0.
- While full, pulse in_vld_i and out_rdy_i together: level_o stays 16, the head advances, and the new triple lands at the tail.
- Continuous push and pop for 100 cycles with random out_rdy_i at 50%: no loss, order preserved, level_o matches a scoreboard every cycle, overflow_o=0 (the stimulus respects almost_full_o).
- Assert rst with 5 entries stored and in_vld_i=1 in the same cycle: the next cycle shows level_o=0, out_vld_o=0, and the simultaneous push is not stored.
